// File: rtl/alu_seq_driver.sv
// alu_seq_driver: multi-byte initiator for an 8-bit combinational ALU.
// Accepts N_BYTES-wide commands, drives the ALU one byte per cycle LSB first with
// carry chained through a local register, and returns the assembled result.
// Optional feature macro: ALU_SEQ_ZFLAG_EN (registered zero flag on rsp_zero).
module alu_seq_driver #(
  parameter int unsigned N_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [8*N_BYTES-1:0]   cmd_a,
  input  logic [8*N_BYTES-1:0]   cmd_b,
  input  logic                   cmd_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*N_BYTES-1:0]   rsp_y,
  output logic                   rsp_cout,
  output logic                   rsp_ovf,
  output logic                   rsp_zero,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic                   alu_cy,
  output logic [1:0]             alu_op,
  input  logic [7:0]             alu_y,
  input  logic                   alu_st
);

  localparam int unsigned W    = 8 * N_BYTES;
  localparam int unsigned IdxW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [1:0]        r_op;
  logic [W-1:0]      r_a, r_b, r_y;
  logic              r_cy, r_ovf;
  logic [IdxW-1:0]   r_idx;

  logic [IdxW+2:0]   w_ofs;
  logic [7:0]        w_a_byte, w_b_byte;
  logic              w_arith, w_last, w_accept, w_cout;
  logic [W-1:0]      w_y_next;

  assign w_ofs    = {r_idx, 3'b000};
  assign w_a_byte = r_a[w_ofs +: 8];
  assign w_b_byte = r_b[w_ofs +: 8];
  // Subtraction is issued as A + ~B + 1 on the ALU's add op.
  assign w_arith  = (r_op == 2'b01) || (r_op == 2'b10);
  assign w_last   = (r_idx == IdxW'(N_BYTES - 1));
  assign w_accept = cmd_valid && (r_state == StIdle);
  // Carry out of bit 7, reconstructed from the driven operands and the ALU sum bit.
  assign w_cout   = (alu_a[7] & alu_b[7]) | ((alu_a[7] | alu_b[7]) & ~alu_y[7]);

  // Result register with the current byte replaced by the ALU output.
  always_comb begin
    w_y_next            = r_y;
    w_y_next[w_ofs +: 8] = alu_y;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state, handshake outputs and ALU drive.
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_cy       = 1'b0;
    alu_op       = 2'b00;
    unique case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_next = StRun;
      end
      StRun: begin
        alu_a  = w_a_byte;
        alu_cy = r_cy;
        unique case (r_op)
          2'b01:   begin alu_b = w_b_byte;  alu_op = 2'b01; end
          2'b10:   begin alu_b = ~w_b_byte; alu_op = 2'b01; end
          2'b11:   alu_op = 2'b11;
          default: alu_op = 2'b00;
        endcase
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Command latch, byte sequencing, carry chain and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= 2'b00;
      r_a   <= '0;
      r_b   <= '0;
      r_y   <= '0;
      r_cy  <= 1'b0;
      r_ovf <= 1'b0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_op  <= cmd_op;
      r_a   <= cmd_a;
      r_b   <= cmd_b;
      r_idx <= '0;
      r_cy  <= (cmd_op == 2'b01) ? cmd_cin : (cmd_op == 2'b10);
    end else if (r_state == StRun) begin
      r_y <= w_y_next;
      if (!w_last) r_idx <= r_idx + IdxW'(1);
      if (w_arith) r_cy <= w_cout;
      if (w_last)  r_ovf <= w_arith & alu_st;
    end
  end

  assign rsp_y    = r_y;
  assign rsp_cout = r_cy;
  assign rsp_ovf  = r_ovf;

`ifdef ALU_SEQ_ZFLAG_EN
  logic r_zero;

  // Zero flag taken on the DONE entry edge, including the byte captured on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_zero <= 1'b0;
    else if ((r_state == StRun) && w_last) r_zero <= (w_y_next == '0);
  end

  assign rsp_zero = r_zero;
`else
  assign rsp_zero = 1'b0;
`endif

endmodule
